// File: rtl/gen1_scramble_lfsr_if.sv
// Bus between the Gen1 scrambler LFSR stage and its neighbours.
//   slave  : the LFSR stage (takes the word in, drives the registered word
//            plus the per-byte scramble value out)
//   master : the upstream driver / downstream XOR stage view
// Signals:
//   valid_i, data_in[31:0], datak_i[3:0]      word into the stage
//   valid_o, data_o[31:0], datak_o[3:0]       registered word out
//   lfsr_scramble_value[31:0]                 scramble byte per data byte
//   lfsr_state_o[15:0]                        current LFSR state (debug)
interface gen1_scramble_lfsr_if;
  logic        valid_i;
  logic [31:0] data_in;
  logic [3:0]  datak_i;
  logic        valid_o;
  logic [31:0] data_o;
  logic [3:0]  datak_o;
  logic [31:0] lfsr_scramble_value;
  logic [15:0] lfsr_state_o;

  modport slave (
    input  valid_i, data_in, datak_i,
    output valid_o, data_o, datak_o, lfsr_scramble_value, lfsr_state_o
  );

  modport master (
    output valid_i, data_in, datak_i,
    input  valid_o, data_o, datak_o, lfsr_scramble_value, lfsr_state_o
  );
endinterface

// File: rtl/gen1_scramble_lfsr.sv
// Gen1 (8b/10b) scrambler LFSR stage, x4 bytes per clock.
// Produces one scramble byte per data byte and forwards the data word and K
// flags one clock later so word and scramble value reach the XOR stage
// together. Polynomial x^16+x^5+x^4+x^3+1 (Galois form).
//   COM (K28.5) : scramble byte 00, LFSR reloads SEED
//   SKP (K28.0) : scramble byte 00, LFSR holds
//   other       : scramble byte = next 8 serial outputs, LFSR advances 8
// Ports:
//   clk_i    clock
//   rst_n_i  synchronous active-low reset
//   bus      gen1_scramble_lfsr_if.slave (word in, registered word + value out)

// One byte position of the in-word chain: takes the LFSR state seen before
// this byte and returns the state after it plus this byte's scramble value.
module gen1_scramble_byte #(
  parameter logic [15:0] SEED    = 16'hFFFF,
  parameter logic [7:0]  COM_SYM = 8'hBC,
  parameter logic [7:0]  SKP_SYM = 8'h1C
) (
  input  logic [15:0] state_i,
  input  logic [7:0]  byte_i,
  input  logic        k_i,
  output logic [15:0] state_o,
  output logic [7:0]  val_o
);
  // Eight serial steps; first output bit lands in the MSB of the byte.
  function automatic logic [23:0] adv8(input logic [15:0] s_in);
    logic [15:0] s;
    logic [15:0] n;
    logic [7:0]  v;
    s = s_in;
    v = '0;
    for (int j = 0; j < 8; j++) begin
      v[7-j]   = s[15];
      n[0]     = s[15];
      n[1]     = s[0];
      n[2]     = s[1];
      n[3]     = s[2] ^ s[15];
      n[4]     = s[3] ^ s[15];
      n[5]     = s[4] ^ s[15];
      n[15:6]  = s[14:5];
      s        = n;
    end
    return {v, s};
  endfunction

  logic [23:0] step;
  logic        is_com;
  logic        is_skp;

  assign step   = adv8(state_i);
  assign is_com = k_i && (byte_i == COM_SYM);
  assign is_skp = k_i && (byte_i == SKP_SYM);

  always_comb begin
    state_o = step[15:0];
    val_o   = step[23:16];
    if (is_com) begin
      state_o = SEED;
      val_o   = 8'h00;
    end else if (is_skp) begin
      state_o = state_i;
      val_o   = 8'h00;
    end
  end
endmodule

module gen1_scramble_lfsr #(
  parameter logic [15:0] SEED    = 16'hFFFF,
  parameter logic [7:0]  COM_SYM = 8'hBC,
  parameter logic [7:0]  SKP_SYM = 8'h1C
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  gen1_scramble_lfsr_if.slave  bus
);
  localparam int NUM_LANES = 4;

  logic [15:0] state_q, state_d;
  logic        valid_q, valid_d;
  logic [NUM_LANES-1:0][7:0] data_q, data_d;
  logic [NUM_LANES-1:0]      datak_q, datak_d;
  logic [NUM_LANES-1:0][7:0] val_q, val_d;

  // chain[i] is the LFSR state in front of byte i; chain[NUM_LANES] is the
  // state after the whole word.
  logic [NUM_LANES:0][15:0]  chain;
  logic [NUM_LANES-1:0][7:0] val_w;

  assign chain[0] = state_q;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    gen1_scramble_byte #(
      .SEED    (SEED),
      .COM_SYM (COM_SYM),
      .SKP_SYM (SKP_SYM)
    ) u_byte (
      .state_i (chain[g]),
      .byte_i  (bus.data_in[8*g +: 8]),
      .k_i     (bus.datak_i[g]),
      .state_o (chain[g+1]),
      .val_o   (val_w[g])
    );
  end

  // Idle cycles freeze the LFSR and hold the last word on the outputs;
  // only valid_o drops.
  always_comb begin
    state_d = state_q;
    valid_d = bus.valid_i;
    data_d  = data_q;
    datak_d = datak_q;
    val_d   = val_q;
    if (bus.valid_i) begin
      state_d = chain[NUM_LANES];
      data_d  = bus.data_in;
      datak_d = bus.datak_i;
      val_d   = val_w;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= SEED;
      valid_q <= 1'b0;
      data_q  <= '0;
      datak_q <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      datak_q <= datak_d;
      val_q   <= val_d;
    end
  end

  assign bus.valid_o             = valid_q;
  assign bus.data_o              = data_q;
  assign bus.datak_o             = datak_q;
  assign bus.lfsr_scramble_value = val_q;
  assign bus.lfsr_state_o        = state_q;
endmodule

// File: tb/tb_gen1_scramble_lfsr.sv
// Bench for gen1_scramble_lfsr. The reference model is the scrambler output
// as one long bit sequence starting at SEED: COM rewinds the read pointer to
// 0, SKP leaves it, every other byte reads the next 8 bits.
module tb_gen1_scramble_lfsr;
  localparam logic [15:0] SEED = 16'hFFFF;
  localparam int          N    = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gen1_scramble_lfsr_if bus();

  gen1_scramble_lfsr #(.SEED(SEED), .COM_SYM(8'hBC), .SKP_SYM(8'h1C)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  logic [15:0] st_seq [0:N];
  logic        bit_seq [0:N-1];

  int          idx;
  logic        e_v;
  logic [31:0] e_data;
  logic [3:0]  e_k;
  logic [31:0] e_val;
  int          checks = 0;
  int          fails  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] seq_byte(input int p);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[7-j] = bit_seq[p+j];
    return r;
  endfunction

  task automatic model(input logic v, input logic [31:0] d, input logic [3:0] k);
    logic [7:0] b;
    if (v) begin
      e_v    = 1'b1;
      e_data = d;
      e_k    = k;
      for (int i = 0; i < 4; i++) begin
        b = d[8*i +: 8];
        if (k[i] && b == 8'hBC) begin
          e_val[8*i +: 8] = 8'h00;
          idx = 0;
        end else if (k[i] && b == 8'h1C) begin
          e_val[8*i +: 8] = 8'h00;
        end else begin
          e_val[8*i +: 8] = seq_byte(idx);
          idx += 8;
        end
      end
    end else begin
      e_v = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_valid"}, {31'd0, bus.valid_o}, {31'd0, e_v});
    chk({tag, "_data"},  bus.data_o, e_data);
    chk({tag, "_datak"}, {28'd0, bus.datak_o}, {28'd0, e_k});
    chk({tag, "_val"},   bus.lfsr_scramble_value, e_val);
    chk({tag, "_state"}, {16'd0, bus.lfsr_state_o}, {16'd0, st_seq[idx]});
  endtask

  task automatic word(input string tag, input logic v, input logic [31:0] d, input logic [3:0] k);
    bus.valid_i = v;
    bus.data_in = d;
    bus.datak_i = k;
    @(posedge clk);
    #1;
    model(v, d, k);
    check_all(tag);
  endtask

  // Reset is asserted with a valid word on the bus; that word must be lost.
  task automatic do_rst(input string tag);
    rst_n       = 1'b0;
    bus.valid_i = 1'b1;
    bus.data_in = $urandom;
    bus.datak_i = 4'($urandom);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    idx    = 0;
    e_v    = 1'b0;
    e_data = '0;
    e_k    = '0;
    e_val  = '0;
    check_all(tag);
  endtask

  task automatic rand_word(output logic [31:0] d, output logic [3:0] k);
    int r;
    for (int i = 0; i < 4; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10)      begin d[8*i +: 8] = 8'hBC; k[i] = 1'b1; end
      else if (r < 22) begin d[8*i +: 8] = 8'h1C; k[i] = 1'b1; end
      else if (r < 28) begin d[8*i +: 8] = 8'($urandom); k[i] = 1'b1; end
      else if (r < 32) begin d[8*i +: 8] = (r < 30) ? 8'hBC : 8'h1C; k[i] = 1'b0; end
      else             begin d[8*i +: 8] = 8'($urandom); k[i] = 1'b0; end
    end
  endtask

  initial begin
    logic [15:0] s;
    logic [31:0] d;
    logic [3:0]  k;
    int          st_save;

    // Polynomial arithmetic: shift left, fold x^16 back in as x^5+x^4+x^3+1.
    s = SEED;
    for (int j = 0; j < N; j++) begin
      st_seq[j]  = s;
      bit_seq[j] = s[15];
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h0039 : 16'h0000);
    end
    st_seq[N] = s;

    bus.valid_i = 1'b0;
    bus.data_in = '0;
    bus.datak_i = '0;
    idx = 0; e_v = 0; e_data = 0; e_k = 0; e_val = 0;

    do_rst("reset");

    word("t1", 1'b1, 32'h0000_00BC, 4'b0001);
    chk("t1_const", bus.lfsr_scramble_value, 32'h03E8_FF00);
    word("t2", 1'b1, 32'h0000_0000, 4'b0000);
    chk("t2_const", bus.lfsr_scramble_value, 32'h40E7_4D28);

    word("t3_com", 1'b1, 32'h3322_11BC, 4'b0001);
    word("t3_skp", 1'b1, 32'h441C_1C55, 4'b0110);
    chk("t3_b12", {16'd0, bus.lfsr_scramble_value[23:8]}, 32'd0);
    chk("t3_b3", {24'd0, bus.lfsr_scramble_value[31:24]}, {24'd0, seq_byte(32)});

    word("t4_com2", 1'b1, 32'h00BC_1234, 4'b0100);
    chk("t4_b3", {24'd0, bus.lfsr_scramble_value[31:24]}, 32'h0000_00FF);
    word("t4_next", 1'b1, 32'h0000_0000, 4'b0000);
    chk("t4_b0", {24'd0, bus.lfsr_scramble_value[7:0]}, 32'h0000_00E8);

    st_save = idx;
    for (int i = 0; i < 5; i++) word("t5_idle", 1'b0, $urandom, 4'($urandom));
    chk("t5_hold", {16'd0, bus.lfsr_state_o}, {16'd0, st_seq[st_save]});
    word("t5_resume", 1'b1, 32'h0102_0304, 4'b0000);

    for (int n = 0; n < 600; n++) begin
      rand_word(d, k);
      if (idx > N - 200) begin d[7:0] = 8'hBC; k[0] = 1'b1; end
      if ($urandom_range(0, 99) < 2) do_rst("rnd_rst");
      else word("rnd", ($urandom_range(0, 99) < 80), d, k);
    end

    word("t6_pre", 1'b1, 32'hDEAD_BEEF, 4'b0000);
    do_rst("t6_rst");
    word("t6_d", 1'b1, 32'h0000_0000, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
